// File: rtl/bf_operand_agu_pkg.sv
// Shared types and constants for the radix-2 butterfly operand address generator.
// State encodings, per-phase slot positions within the 8-cycle butterfly, default sizes.
package bf_operand_agu_pkg;

  localparam int LOG2N_DEFAULT    = 4;
  localparam int ROW_BITS_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } aguState_e;

  // Read slots: the address issued in phase p feeds the butterfly in phase p+1
  localparam logic [2:0] PH_TW_RE  = 3'd0;
  localparam logic [2:0] PH_BI_IM  = 3'd1;
  localparam logic [2:0] PH_TW_IM  = 3'd2;
  localparam logic [2:0] PH_A_RE   = 3'd3;
  localparam logic [2:0] PH_A_IM   = 3'd4;
  localparam logic [2:0] PH_HOLD_A = 3'd5;
  localparam logic [2:0] PH_HOLD_B = 3'd6;
  localparam logic [2:0] PH_BR     = 3'd7;

  // Write slots: r1 of this butterfly, r2 of the previous one
  localparam logic [2:0] PH_WR_R2R = 3'd0;
  localparam logic [2:0] PH_WR_R2I = 3'd1;
  localparam logic [2:0] PH_WR_R1R = 3'd6;
  localparam logic [2:0] PH_WR_R1I = 3'd7;

  function automatic int stageBits(input int log2n);
    return (log2n > 1) ? $clog2(log2n) : 1;
  endfunction

endpackage

// File: rtl/bf_operand_agu_if.sv
// Control/address bundle between the AGU (master) and the RAM/ROM/butterfly side (slave).
// BF_AGU_STATUS_EN adds the xStageIdx/xBflyIdx status outputs.
interface bf_operand_agu_if
  import bf_operand_agu_pkg::*;
#(
  parameter int LOG2N    = LOG2N_DEFAULT,
  parameter int ROW_BITS = ROW_BITS_DEFAULT
);
  localparam int ADDR_BITS  = ROW_BITS + LOG2N + 1;
  localparam int LOG2N_BITS = stageBits(LOG2N);

  logic                 xGo;
  logic [ROW_BITS-1:0]  xRowBase;
  logic [ADDR_BITS-1:0] xRdAddr;
  logic                 xRdTw;
  logic [ADDR_BITS-1:0] xWrAddr;
  logic                 xWrEn;
  logic                 xBfStart;
  logic                 xBfReset;
  logic                 xBfTri;
  logic                 xBusy;
  logic                 xDone;

`ifdef BF_AGU_STATUS_EN
  logic [LOG2N_BITS-1:0] xStageIdx;
  logic [LOG2N-2:0]      xBflyIdx;

  modport master (
    input  xGo, xRowBase,
    output xRdAddr, xRdTw, xWrAddr, xWrEn, xBfStart, xBfReset, xBfTri, xBusy, xDone,
    output xStageIdx, xBflyIdx
  );
  modport slave (
    output xGo, xRowBase,
    input  xRdAddr, xRdTw, xWrAddr, xWrEn, xBfStart, xBfReset, xBfTri, xBusy, xDone,
    input  xStageIdx, xBflyIdx
  );
`else
  modport master (
    input  xGo, xRowBase,
    output xRdAddr, xRdTw, xWrAddr, xWrEn, xBfStart, xBfReset, xBfTri, xBusy, xDone
  );
  modport slave (
    output xGo, xRowBase,
    input  xRdAddr, xRdTw, xWrAddr, xWrEn, xBfStart, xBfReset, xBfTri, xBusy, xDone
  );
`endif

endinterface

// File: rtl/bf_operand_agu_index.sv
// Combinational DIT index unit: (stage, butterfly) -> top index a, bottom index bi, twiddle index.
module bf_agu_index
  import bf_operand_agu_pkg::*;
#(
  parameter int LOG2N      = LOG2N_DEFAULT,
  parameter int LOG2N_BITS = stageBits(LOG2N)
) (
  input  logic [LOG2N_BITS-1:0] stage,
  input  logic [LOG2N-2:0]      bfly,
  output logic [LOG2N-1:0]      a,
  output logic [LOG2N-1:0]      bi,
  output logic [LOG2N-2:0]      tw
);

  logic [LOG2N-1:0] bExt;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] lowBits;
  logic [LOG2N-1:0] highBits;

  // Insert a zero at bit position `stage` of the butterfly number to get a
  always_comb begin
    bExt     = {1'b0, bfly};
    span     = LOG2N'(1) << stage;
    lowBits  = bExt & (span - LOG2N'(1));
    highBits = (bExt & ~(span - LOG2N'(1))) << 1;
    a        = highBits | lowBits;
    bi       = a | span;
    tw       = (LOG2N-1)'(lowBits << (LOG2N - 1 - 32'(stage)));
  end

endmodule

// File: rtl/bf_operand_agu.sv
// Operand/result address sequencer for the 8-cycle radix-2 butterfly; runs one in-place DIT FFT per xGo.
// BF_AGU_STATUS_EN adds xStageIdx/xBflyIdx status outputs on the bus.
module bf_operand_agu
  import bf_operand_agu_pkg::*;
#(
  parameter int LOG2N    = LOG2N_DEFAULT,
  parameter int ROW_BITS = ROW_BITS_DEFAULT
) (
  input logic xClock,
  input logic xReset,
  bf_operand_agu_if.master bus
);

  localparam int ADDR_BITS  = ROW_BITS + LOG2N + 1;
  localparam int LOG2N_BITS = stageBits(LOG2N);
  localparam int HALF       = 1 << (LOG2N - 1);
  localparam logic [LOG2N-2:0]      BFLY_LAST  = (LOG2N-1)'(HALF - 1);
  localparam logic [LOG2N_BITS-1:0] STAGE_LAST = LOG2N_BITS'(LOG2N - 1);

  aguState_e             state, stateNext;
  logic [2:0]            phase, phaseNext;
  logic [LOG2N-2:0]      bfly, bflyNext, idxBfly;
  logic [LOG2N_BITS-1:0] stage, stageNext, idxStage;
  logic [ROW_BITS-1:0]   row;
  logic [LOG2N-1:0]      idxA, idxBi, aHold, biPrev;
  logic [LOG2N-2:0]      idxTw;
  logic                  lastBfly, lastStage, firstBfly, lastSlot;

  logic [ADDR_BITS-1:0]  rdAddr, wrAddr;
  logic                  rdTw, wrEn, bfStart, bfReset, busy, done;

  function automatic logic [ADDR_BITS-1:0] dataAddr(input logic [ROW_BITS-1:0] r,
                                                    input logic [LOG2N-1:0] idx,
                                                    input logic im);
    return {r, idx, im};
  endfunction

  function automatic logic [ADDR_BITS-1:0] twAddr(input logic [LOG2N-2:0] t, input logic im);
    return {{(ROW_BITS + 1){1'b0}}, t, im};
  endfunction

  assign lastBfly  = (bfly == BFLY_LAST);
  assign lastStage = (stage == STAGE_LAST);
  assign firstBfly = (stage == '0) && (bfly == '0);
  assign lastSlot  = lastBfly && lastStage && (phase == PH_BR);

  always_ff @(posedge xClock) begin
    if (!xReset) begin
      state <= ST_IDLE;
      phase <= '0;
      bfly  <= '0;
      stage <= '0;
    end else begin
      state <= stateNext;
      phase <= phaseNext;
      bfly  <= bflyNext;
      stage <= stageNext;
    end
  end

  // Row and the current butterfly's indices are captured before phase 7 retargets the index unit
  always_ff @(posedge xClock) begin
    if (state == ST_IDLE && bus.xGo) row <= bus.xRowBase;
    if (state == ST_RUN && phase == PH_WR_R1R) begin
      aHold  <= idxA;
      biPrev <= idxBi;
    end
  end

  always_comb begin
    stateNext = state;
    phaseNext = phase;
    bflyNext  = bfly;
    stageNext = stage;
    case (state)
      ST_IDLE:  if (bus.xGo) stateNext = ST_PRIME;
      ST_PRIME: stateNext = ST_RUN;
      ST_RUN: begin
        phaseNext = phase + 3'd1;
        if (phase == PH_BR) begin
          bflyNext = bfly + (LOG2N-1)'(1);
          if (lastBfly) begin
            stageNext = lastStage ? '0 : stage + LOG2N_BITS'(1);
            if (lastStage) stateNext = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        phaseNext = phase + 3'd1;
        if (phase[0]) begin
          phaseNext = '0;
          stateNext = ST_DONE;
        end
      end
      ST_DONE:  stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  // Phase 7 looks one butterfly ahead to prefetch the next bottom operand
  assign idxStage = (state == ST_RUN && phase == PH_BR) ? stageNext : stage;
  assign idxBfly  = (state == ST_RUN && phase == PH_BR) ? bflyNext  : bfly;

  bf_agu_index #(
    .LOG2N      (LOG2N),
    .LOG2N_BITS (LOG2N_BITS)
  ) uIndex (
    .stage (idxStage),
    .bfly  (idxBfly),
    .a     (idxA),
    .bi    (idxBi),
    .tw    (idxTw)
  );

  always_comb begin
    rdAddr  = '0;
    rdTw    = 1'b0;
    wrAddr  = '0;
    wrEn    = 1'b0;
    bfStart = 1'b0;
    bfReset = 1'b1;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_PRIME: begin
        busy   = 1'b1;
        rdAddr = dataAddr(row, idxBi, 1'b0);
      end
      ST_RUN: begin
        busy    = 1'b1;
        bfReset = 1'b0;
        bfStart = firstBfly && (phase == PH_TW_RE);
        case (phase)
          PH_TW_RE: begin
            rdTw   = 1'b1;
            rdAddr = twAddr(idxTw, 1'b0);
          end
          PH_BI_IM: rdAddr = dataAddr(row, idxBi, 1'b1);
          PH_TW_IM: begin
            rdTw   = 1'b1;
            rdAddr = twAddr(idxTw, 1'b1);
          end
          PH_A_RE:  rdAddr = dataAddr(row, idxA, 1'b0);
          PH_A_IM, PH_HOLD_A, PH_HOLD_B: rdAddr = dataAddr(row, idxA, 1'b1);
          PH_BR:    rdAddr = lastSlot ? dataAddr(row, aHold, 1'b1) : dataAddr(row, idxBi, 1'b0);
        endcase
        case (phase)
          PH_WR_R2R, PH_WR_R2I: begin
            wrEn   = !firstBfly;
            wrAddr = firstBfly ? '0 : dataAddr(row, biPrev, phase[0]);
          end
          PH_WR_R1R: begin
            wrEn   = 1'b1;
            wrAddr = dataAddr(row, idxA, 1'b0);
          end
          PH_WR_R1I: begin
            wrEn   = 1'b1;
            wrAddr = dataAddr(row, aHold, 1'b1);
          end
          default: ;
        endcase
      end
      ST_DRAIN: begin
        busy    = 1'b1;
        bfReset = 1'b0;
        wrEn    = 1'b1;
        wrAddr  = dataAddr(row, biPrev, phase[0]);
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign bus.xRdAddr  = rdAddr;
  assign bus.xRdTw    = rdTw;
  assign bus.xWrAddr  = wrAddr;
  assign bus.xWrEn    = wrEn;
  assign bus.xBfStart = bfStart;
  assign bus.xBfReset = bfReset;
  assign bus.xBfTri   = ~wrEn;
  assign bus.xBusy    = busy;
  assign bus.xDone    = done;

`ifdef BF_AGU_STATUS_EN
  assign bus.xStageIdx = busy ? stage : '0;
  assign bus.xBflyIdx  = busy ? bfly  : '0;
`endif

endmodule

// File: tb/tb_bf_operand_agu.sv
// Randomized bench for bf_operand_agu: per-cycle schedule model plus a delta-input RAM/butterfly model.
module tb_bf_operand_agu;

  localparam int LOG2N     = 4;
  localparam int ROW_BITS  = 4;
  localparam int N         = 1 << LOG2N;
  localparam int HALF      = N / 2;
  localparam int ADDR_BITS = ROW_BITS + LOG2N + 1;
  localparam int NBFLY     = LOG2N * HALF;
  localparam int RUN_LEN   = NBFLY * 8;
  localparam int DRAIN0    = 2 + RUN_LEN;
  localparam int DONE_C    = DRAIN0 + 2;

  logic xClock = 1'b0;
  logic xReset = 1'b0;
  always #5 xClock = ~xClock;

  bf_operand_agu_if #(.LOG2N(LOG2N), .ROW_BITS(ROW_BITS)) agu ();
  bf_operand_agu #(.LOG2N(LOG2N), .ROW_BITS(ROW_BITS)) dut (
    .xClock (xClock),
    .xReset (xReset),
    .bus    (agu)
  );

  int total = 0;
  int bad   = 0;
  int mem[1 << ADDR_BITS];

  typedef struct packed {
    int rdAddr; int rdTw; int wrEn; int wrAddr;
    int start;  int bfReset; int busy; int done;
    int stage;  int bfly;
  } exp_t;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int aOf(input int s, input int b);
    int span = 1 << s;
    return (b / span) * 2 * span + (b % span);
  endfunction
  function automatic int biOf(input int s, input int b);
    return aOf(s, b) + (1 << s);
  endfunction
  function automatic int twOf(input int s, input int b);
    return (b % (1 << s)) * (1 << (LOG2N - 1 - s));
  endfunction
  function automatic int dAddr(input int row, input int idx, input int im);
    return row * 2 * N + idx * 2 + im;
  endfunction

  // Expected outputs for cycle c of a job; cycle 0 is the cycle xGo is presented
  function automatic exp_t expectAt(input int c, input int row);
    exp_t e;
    e = '0;
    e.bfReset = 1;
    if (c == 1) begin
      e.busy   = 1;
      e.rdAddr = dAddr(row, biOf(0, 0), 0);
    end else if (c >= 2 && c < DRAIN0) begin
      int k = c - 2;
      int p = k % 8;
      int n = k / 8;
      int s = n / HALF;
      int b = n % HALF;
      e.busy = 1; e.bfReset = 0; e.start = (k == 0);
      e.stage = s; e.bfly = b;
      case (p)
        0: begin e.rdTw = 1; e.rdAddr = twOf(s, b) * 2; end
        1: e.rdAddr = dAddr(row, biOf(s, b), 1);
        2: begin e.rdTw = 1; e.rdAddr = twOf(s, b) * 2 + 1; end
        3: e.rdAddr = dAddr(row, aOf(s, b), 0);
        7: e.rdAddr = (n == NBFLY - 1) ? dAddr(row, aOf(s, b), 1)
                                       : dAddr(row, biOf((n + 1) / HALF, (n + 1) % HALF), 0);
        default: e.rdAddr = dAddr(row, aOf(s, b), 1);
      endcase
      if (p >= 6) begin
        e.wrEn = 1; e.wrAddr = dAddr(row, aOf(s, b), p - 6);
      end else if (p <= 1 && n > 0) begin
        e.wrEn = 1; e.wrAddr = dAddr(row, biOf((n - 1) / HALF, (n - 1) % HALF), p);
      end
    end else if (c == DRAIN0 || c == DRAIN0 + 1) begin
      e.busy = 1; e.bfReset = 0; e.wrEn = 1;
      e.wrAddr = dAddr(row, biOf(LOG2N - 1, HALF - 1), c - DRAIN0);
    end else if (c == DONE_C) begin
      e.done = 1;
    end
    return e;
  endfunction

  task automatic compareAt(input int c, input int row);
    exp_t e = expectAt(c, row);
    checkVal($sformatf("c%0d rdAddr", c), agu.xRdAddr, e.rdAddr);
    checkVal($sformatf("c%0d rdTw", c), agu.xRdTw, e.rdTw);
    checkVal($sformatf("c%0d wrEn", c), agu.xWrEn, e.wrEn);
    checkVal($sformatf("c%0d wrAddr", c), agu.xWrAddr, e.wrAddr);
    checkVal($sformatf("c%0d bfStart", c), agu.xBfStart, e.start);
    checkVal($sformatf("c%0d bfReset", c), agu.xBfReset, e.bfReset);
    checkVal($sformatf("c%0d bfTri", c), agu.xBfTri, 32'(e.wrEn == 0));
    checkVal($sformatf("c%0d busy", c), agu.xBusy, e.busy);
    checkVal($sformatf("c%0d done", c), agu.xDone, e.done);
`ifdef BF_AGU_STATUS_EN
    checkVal($sformatf("c%0d stageIdx", c), agu.xStageIdx, e.stage);
    checkVal($sformatf("c%0d bflyIdx", c), agu.xBflyIdx, e.bfly);
`endif
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, " bfReset"}, agu.xBfReset, 1);
    checkVal({tag, " bfTri"}, agu.xBfTri, 1);
    checkVal({tag, " wrEn"}, agu.xWrEn, 0);
    checkVal({tag, " busy"}, agu.xBusy, 0);
    checkVal({tag, " done"}, agu.xDone, 0);
    checkVal({tag, " rdAddr"}, agu.xRdAddr, 0);
    checkVal({tag, " bfStart"}, agu.xBfStart, 0);
  endtask

  // One job; abortC > 0 pulls xReset low during that cycle instead of finishing
  task automatic runJob(input int row, input bit spam, input int abortC);
    int prevAddr = 0, prevTw = 0, prevValid = 0;
    int bRe = 0, bIm = 0, aRe = 0, aIm = 0, r1Re = 0, r1Im = 0, r2Re = 0, r2Im = 0;
    for (int i = 0; i < (1 << ADDR_BITS); i++) mem[i] = 0;
    mem[dAddr(row, 0, 0)] = 1024;
    @(negedge xClock);
    checkIdle("pre-go");
    agu.xGo = 1'b1;
    agu.xRowBase = ROW_BITS'(row);
    for (int c = 1; c <= DONE_C; c++) begin
      int d, val;
      @(negedge xClock);
      compareAt(c, row);
      if (row == 3) begin
        if (c == 1) checkVal("prime addr row3", agu.xRdAddr, 98);
        if (c == 2) checkVal("first tw addr", agu.xRdAddr, 0);
        if (c == 90) checkVal("s1b3 tw re", agu.xRdAddr, 8);
        if (c == 91) checkVal("s1b3 bi im", agu.xRdAddr, 111);
        if (c == 93) checkVal("s1b3 a re", agu.xRdAddr, 106);
        if (c == 96) checkVal("s1b3 r1r wr", agu.xWrAddr, 106);
        if (c == 97) checkVal("s1b3 r1i wr", agu.xWrAddr, 107);
        if (c == 98) checkVal("s1b3 r2r wr", agu.xWrAddr, 110);
        if (c == 99) checkVal("s1b3 r2i wr", agu.xWrAddr, 111);
      end
      if (c == abortC) begin
        agu.xGo = 1'b0;
        xReset = 1'b0;
        @(negedge xClock);
        checkIdle("post-abort");
        @(negedge xClock);
        checkVal("abort no write", agu.xWrEn, 0);
        checkVal("abort no done", agu.xDone, 0);
        xReset = 1'b1;
        return;
      end
      // Butterfly operands arrive one cycle after their address was issued
      d = (prevValid != 0 && prevTw == 0) ? mem[prevAddr] : 0;
      if (c >= 2 && c < DRAIN0) begin
        case ((c - 2) % 8)
          0: bRe = d;
          2: bIm = d;
          4: aRe = d;
          5: begin
            // Delta input: the bottom operand is always zero, so the twiddle never matters
            aIm = d;
            r1Re = (aRe + bRe) >>> 1; r1Im = (aIm + bIm) >>> 1;
            r2Re = (aRe - bRe) >>> 1; r2Im = (aIm - bIm) >>> 1;
          end
          default: ;
        endcase
      end
      if (agu.xWrEn) begin
        val = 0;
        if (c >= DRAIN0) val = (c == DRAIN0) ? r2Re : r2Im;
        else case ((c - 2) % 8)
          0: val = r2Re;
          1: val = r2Im;
          6: val = r1Re;
          7: val = r1Im;
          default: val = 0;
        endcase
        mem[agu.xWrAddr] = val;
      end
      prevAddr = int'(agu.xRdAddr); prevTw = int'(agu.xRdTw); prevValid = int'(agu.xBusy);
      agu.xGo = (spam && c < DONE_C) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (spam) agu.xRowBase = ROW_BITS'($urandom_range(0, N - 1));
    end
    for (int idx = 0; idx < N; idx++) begin
      checkVal($sformatf("bin%0d re", idx), mem[dAddr(row, idx, 0)], 64);
      checkVal($sformatf("bin%0d im", idx), mem[dAddr(row, idx, 1)], 0);
    end
  endtask

  initial begin
    agu.xGo = 1'b0;
    agu.xRowBase = '0;
    xReset = 1'b0;
    repeat (3) @(negedge xClock);
    checkIdle("reset");
    checkVal("reset wrAddr", agu.xWrAddr, 0);
    checkVal("reset rdTw", agu.xRdTw, 0);
    xReset = 1'b1;
    runJob(3, 1'b0, 0);
    runJob($urandom_range(0, N - 1), 1'b1, 0);
    runJob($urandom_range(0, N - 1), 1'b1, 0);
    runJob(5, 1'b1, 2 + 2 * HALF * 8 + 4 * 8 + 3);
    runJob($urandom_range(0, N - 1), 1'b0, 2 + $urandom_range(0, RUN_LEN - 1));
    runJob($urandom_range(0, N - 1), 1'b1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
